// File: rtl/vlc_bitstream_packer.sv
// Packs {sum, codeword_length} codewords MSB-first into 32-bit words.
// Residual bits are flushed zero-padded at frame end, along with the frame bit count.
module vlc_bitstream_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              input_start,
  input  logic              input_end,
  input  logic              input_valid,
  input  logic [WORD_W-1:0] sum,
  input  logic [31:0]       codeword_length,
  output logic              output_valid,
  output logic              output_start,
  output logic              output_end,
  output logic [WORD_W-1:0] output_word,
  output logic [CNT_W-1:0]  output_bit_count,
  output logic              length_error
);

  localparam int unsigned ACC_W  = 2 * WORD_W;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned PEND_W = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  // Stage 1: clamp length, mask codeword
  logic              s1_valid_q, s1_start_q, s1_end_q;
  logic [LEN_W-1:0]  s1_len_q;
  logic [WORD_W-1:0] s1_bits_q;
  logic              length_error_q;
  logic [LEN_W-1:0]  len_clamp;
  logic [WORD_W-1:0] len_mask;

  always_comb begin
    len_clamp = (codeword_length > 32'(WORD_W)) ? LEN_W'(WORD_W) : LEN_W'(codeword_length);
    len_mask  = WORD_W'((ACC_W'(1) << len_clamp) - ACC_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_start_q     <= 1'b0;
      s1_end_q       <= 1'b0;
      s1_len_q       <= '0;
      s1_bits_q      <= '0;
      length_error_q <= 1'b0;
    end else begin
      s1_valid_q <= input_valid;
      if (input_valid) begin
        s1_start_q <= input_start;
        s1_end_q   <= input_end;
        s1_len_q   <= len_clamp;
        s1_bits_q  <= sum & len_mask;
        if (codeword_length > 32'(WORD_W)) length_error_q <= 1'b1;
      end
    end
  end

  // Stage 2: accumulate, emit words, frame state machine
  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              output_valid_q, output_valid_d;
  logic              output_start_q, output_start_d;
  logic              output_end_q, output_end_d;
  logic [WORD_W-1:0] output_word_q, output_word_d;
  logic [CNT_W-1:0]  output_bit_count_q, output_bit_count_d;

  logic              accept, full, first_eff;
  logic [ACC_W-1:0]  base_acc, appended, acc_after;
  logic [PEND_W-1:0] base_pend, new_pend, resid;
  logic [CNT_W-1:0]  base_cnt, new_cnt;

  always_comb begin
    accept    = s1_valid_q && ((state_q == ST_IDLE && s1_start_q) || state_q == ST_ACTIVE);
    base_acc  = s1_start_q ? '0 : acc_q;
    base_pend = s1_start_q ? '0 : pend_q;
    base_cnt  = s1_start_q ? '0 : cnt_q;
    // Left-align the codeword, then slot it directly below the pending bits
    appended  = base_acc |
                (({s1_bits_q, {WORD_W{1'b0}}} << (PEND_W'(WORD_W) - PEND_W'(s1_len_q))) >> base_pend);
    new_pend  = base_pend + PEND_W'(s1_len_q);
    new_cnt   = base_cnt + CNT_W'(s1_len_q);
    full      = new_pend >= PEND_W'(WORD_W);
    resid     = full ? (new_pend - PEND_W'(WORD_W)) : new_pend;
    acc_after = full ? (appended << WORD_W) : appended;
    first_eff = s1_start_q | first_q;
  end

  always_comb begin
    state_d            = state_q;
    acc_d              = acc_q;
    pend_d             = pend_q;
    cnt_d              = cnt_q;
    first_d            = first_q;
    output_valid_d     = 1'b0;
    output_start_d     = 1'b0;
    output_end_d       = 1'b0;
    output_word_d      = '0;
    output_bit_count_d = '0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (accept) begin
          state_d = ST_ACTIVE;
          acc_d   = acc_after;
          pend_d  = resid;
          cnt_d   = new_cnt;
          first_d = first_eff;
          if (full) begin
            output_valid_d = 1'b1;
            output_word_d  = appended[ACC_W-1:WORD_W];
            output_start_d = first_eff;
            first_d        = 1'b0;
          end
          if (s1_end_q) begin
            if (resid == '0 || !full) begin
              // Frame closes this cycle: full word, residual word or empty-frame word
              output_valid_d     = 1'b1;
              output_word_d      = appended[ACC_W-1:WORD_W];
              output_start_d     = first_eff;
              output_end_d       = 1'b1;
              output_bit_count_d = new_cnt;
              first_d            = 1'b0;
              acc_d              = '0;
              pend_d             = '0;
              state_d            = ST_IDLE;
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        output_valid_d     = 1'b1;
        output_word_d      = acc_q[ACC_W-1:WORD_W];
        output_start_d     = first_q;
        output_end_d       = 1'b1;
        output_bit_count_d = cnt_q;
        first_d            = 1'b0;
        acc_d              = '0;
        pend_d             = '0;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      acc_q              <= '0;
      pend_q             <= '0;
      cnt_q              <= '0;
      first_q            <= 1'b0;
      output_valid_q     <= 1'b0;
      output_start_q     <= 1'b0;
      output_end_q       <= 1'b0;
      output_word_q      <= '0;
      output_bit_count_q <= '0;
    end else begin
      state_q            <= state_d;
      acc_q              <= acc_d;
      pend_q             <= pend_d;
      cnt_q              <= cnt_d;
      first_q            <= first_d;
      output_valid_q     <= output_valid_d;
      output_start_q     <= output_start_d;
      output_end_q       <= output_end_d;
      output_word_q      <= output_word_d;
      output_bit_count_q <= output_bit_count_d;
    end
  end

  assign output_valid     = output_valid_q;
  assign output_start     = output_start_q;
  assign output_end       = output_end_q;
  assign output_word      = output_word_q;
  assign output_bit_count = output_bit_count_q;
  assign length_error     = length_error_q;

endmodule

// File: tb/tb_vlc_bitstream_packer.sv
// Directed bench for vlc_bitstream_packer: hand-computed words, flags, counts and latency.
module tb_vlc_bitstream_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        input_start, input_end, input_valid;
  logic [31:0] sum, codeword_length;
  logic        output_valid, output_start, output_end;
  logic [31:0] output_word;
  logic [15:0] output_bit_count;
  logic        length_error;

  vlc_bitstream_packer #(.WORD_W(32), .CNT_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .input_start      (input_start),
    .input_end        (input_end),
    .input_valid      (input_valid),
    .sum              (sum),
    .codeword_length  (codeword_length),
    .output_valid     (output_valid),
    .output_start     (output_start),
    .output_end       (output_end),
    .output_word      (output_word),
    .output_bit_count (output_bit_count),
    .length_error     (length_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        s;
    logic        e;
    logic [15:0] c;
    int          cyc;
  } obs_t;

  obs_t q[$];
  int   cyc = 0;
  int   drv_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted word away from the active edge
  always @(negedge clk) begin
    if (reset_n && output_valid)
      q.push_back('{output_word, output_start, output_end, output_bit_count, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit st, input bit en, input logic [31:0] s, input logic [31:0] l);
    @(negedge clk);
    input_valid     = 1'b1;
    input_start     = st;
    input_end       = en;
    sum             = s;
    codeword_length = l;
    drv_cyc         = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      input_valid     = 1'b0;
      input_start     = 1'b0;
      input_end       = 1'b0;
      sum             = '0;
      codeword_length = '0;
    end
  endtask

  // Pop the next emitted word (bounded wait) and compare; lat < 0 skips the latency check
  task automatic expect_word(input string tag, input logic [31:0] w, input bit s, input bit e,
                             input logic [15:0] c, input int lat);
    obs_t o;
    int   t = 0;
    while (q.size() == 0 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({tag, "_present"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      o = q.pop_front();
      chk({tag, "_word"}, 64'(o.w), 64'(w));
      chk({tag, "_start"}, 64'(o.s), 64'(s));
      chk({tag, "_end"}, 64'(o.e), 64'(e));
      if (e) chk({tag, "_count"}, 64'(o.c), 64'(c));
      if (lat >= 0) chk({tag, "_latency"}, 64'(o.cyc - drv_cyc), 64'(lat));
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    input_valid     = 1'b0;
    input_start     = 1'b0;
    input_end       = 1'b0;
    sum             = '0;
    codeword_length = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(output_valid), 64'd0);
    chk("rst_word", 64'(output_word), 64'd0);
    chk("rst_flags", 64'({output_start, output_end, length_error}), 64'd0);
    chk("rst_count", 64'(output_bit_count), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Short frame: 101 1 1111
    send(1, 0, 32'h5, 32'd3);
    send(0, 0, 32'h1, 32'd1);
    send(0, 1, 32'hF, 32'd4);
    idle(1);
    expect_word("short", 32'hBF000000, 1, 1, 16'd8, 2);
    idle(3);

    // Exact fill: no flush word afterwards
    send(1, 0, 32'h12, 32'd8);
    send(0, 0, 32'h34, 32'd8);
    send(0, 0, 32'h56, 32'd8);
    send(0, 1, 32'h78, 32'd8);
    idle(1);
    expect_word("exact", 32'h12345678, 1, 1, 16'd32, 2);
    idle(4);
    chk("exact_noflush", 64'(q.size()), 64'd0);

    // Straddle: full word then FLUSH word one cycle later
    send(1, 0, 32'h3FFFFFFF, 32'd30);
    send(0, 1, 32'h5, 32'd4);
    idle(1);
    expect_word("straddle0", 32'hFFFFFFFD, 1, 0, 16'd0, 2);
    expect_word("straddle1", 32'h40000000, 0, 1, 16'd34, 3);
    idle(3);

    // Masking: upper bits of sum ignored
    chk("lerr_clear", 64'(length_error), 64'd0);
    send(1, 0, 32'hFFFFFFFF, 32'd3);
    send(0, 1, 32'hFFFFFFF0, 32'd5);
    idle(1);
    expect_word("mask", 32'hF0000000, 1, 1, 16'd8, 2);
    idle(3);

    // Clamp: length 40 appends 32 bits and sets length_error
    send(1, 0, 32'hFFFFFFFF, 32'd40);
    send(0, 1, 32'h0, 32'd4);
    idle(1);
    expect_word("clamp0", 32'hFFFFFFFF, 1, 0, 16'd0, -1);
    expect_word("clamp1", 32'h00000000, 0, 1, 16'd36, -1);
    chk("lerr_set", 64'(length_error), 64'd1);
    idle(3);

    // Empty frame: zero-length start+end codeword
    send(1, 1, 32'hFFFFFFFF, 32'd0);
    idle(1);
    expect_word("empty", 32'h00000000, 1, 1, 16'd0, 2);
    chk("lerr_sticky", 64'(length_error), 64'd1);
    idle(3);

    // Mid-frame reset with 20 bits pending while a word is on the output
    send(1, 0, 32'hABCDE, 32'd20);
    send(0, 0, 32'hFFFFFFFF, 32'd32);
    idle(2);
    #2;
    chk("pre_rst_valid", 64'(output_valid), 64'd1);
    chk("pre_rst_word", 64'(output_word), 64'hABCDEFFF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(output_valid), 64'd0);
    chk("mid_rst_word", 64'(output_word), 64'd0);
    chk("mid_rst_flags", 64'({output_start, output_end, length_error}), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    chk("post_rst_quiet", 64'(q.size()), 64'd0);
    send(1, 1, 32'h1, 32'd4);
    idle(1);
    expect_word("post_rst", 32'h10000000, 1, 1, 16'd4, 2);
    idle(4);
    chk("post_rst_noflush", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vlc_bitstream_packer.md
Name: vlc_bitstream_packer

Overview:
- Downstream of the AC run/level VLC stages.
- Consumes a stream of variable-length codewords, each given as a {sum, codeword_length} pair.
- Packs the codewords MSB-first into a contiguous bitstream and emits aligned 32-bit words.
- Frames are delimited by start/end pulses. At frame end the packer flushes the residual bits zero-padded to a full word and reports the frame's total bit count, so the slice writer can place the data.

Parameters:
- WORD_W, 32, output word width; the only supported value is 32.
- CNT_W, 16, width of the frame bit counter and of output_bit_count.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- input_start  input  1  first codeword of a frame; qualified by input_valid.
- input_end  input  1  last codeword of a frame; qualified by input_valid.
- input_valid  input  1  sum and codeword_length are valid this cycle.
- sum  input  32  codeword bits, right-aligned; bits at and above codeword_length are ignored.
- codeword_length  input  32  number of bits to append, legal range 0..32.
- output_valid  output  1  output_word is valid this cycle.
- output_start  output  1  first word of a frame.
- output_end  output  1  last word of a frame.
- output_word  output  32  packed bits; the first bit of the stream is in bit 31.
- output_bit_count  output  CNT_W  total codeword bits in the frame; valid only with output_end.
- length_error  output  1  sticky flag: a codeword_length greater than 32 was received.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs are 0. The 64-bit accumulator, pending-bit count, frame bit counter, state and pipeline registers are also cleared.
- Reset mid-frame: all residual bits are discarded and no flush word is emitted. The next input_start begins a clean frame.
- Stage 1 (edge N, input_valid=1):
  - Register input_start and input_end.
  - Clamp the length: if codeword_length > 32, use 32 and set length_error (sticky until reset).
  - Mask sum to the low clamped-length bits.
- Stage 2 (edge N+1):
  - Append the masked bits below the pending bits in the accumulator.
  - Add the length to the pending count (0..63) and to the frame bit counter. The frame counter wraps modulo 2^CNT_W.
  - If the pending count reaches ≥32, emit the top 32 bits as output_word, set output_valid=1 and subtract 32 from the pending count.
  - At most one full word is emitted per cycle; 63 pending bits is the worst case and never overflows.
- input_start on an accepted codeword:
  - Clears the pending bits and the frame counter before that codeword is appended.
  - Arms first-word tracking: the next emitted word carries output_start=1.
- Latency: a word completed by the codeword sampled at edge N is presented after edge N+1, for one cycle.
- State machine: IDLE, ACTIVE, FLUSH.
  - IDLE→ACTIVE on an accepted input_start.
  - ACTIVE→IDLE on input_end, when the residual is 0 after the append.
    - If a full word is emitted that cycle, it carries output_end and output_bit_count.
    - Otherwise (empty frame: input_start and input_end on the same zero-length codeword), emit one word 0x00000000 with start=end=1 and output_bit_count=0.
  - ACTIVE→FLUSH on input_end, when the residual is >0 after the append.
    - If a full word is emitted in the same cycle, FLUSH emits the residual word one cycle later.
    - If no full word is emitted, the residual word is emitted in the append cycle and the machine returns to IDLE directly.
  - FLUSH: emit the residual bits left-aligned, low bits zero-padded, with output_end=1 and output_bit_count; then go to IDLE.
- output_start and output_end may both be set on the same word.
- Codeword with length 0: appends nothing, but its start/end flags still act.
- input_valid while IDLE without input_start: the codeword is dropped.
- Protocol: upstream leaves at least one idle cycle between input_end and the next input_start. input_valid during FLUSH is dropped.

Test Plan:
- Short frame: codewords (0x5, len 3, start), (0x1, len 1), (0xF, len 4, end) → one word 0xBF000000, start=end=1, output_bit_count=8, two cycles after the last input.
- Exact fill: lengths 8 with values 0x12, 0x34, 0x56, 0x78 (start on first, end on last) → one word 0x12345678, start=end=1, count=32, no flush word.
- Straddle: (0x3FFFFFFF, len 30, start), then (0x5, len 4, end).
  - Word 0xFFFFFFFD with start=1 after edge N+1.
  - Then word 0x40000000 with end=1 and count=34 on the next cycle (FLUSH).
- Masking and clamp:
  - sum=0xFFFFFFFF, len 3 appends 111 only.
  - len 40 appends 32 bits and sets length_error=1, which stays set across frames until reset.
- Empty frame and reset: start+end on a len-0 codeword → word 0x00000000, start=end=1, count=0.
  - Assert reset_n low mid-frame with 20 bits pending → all outputs drop to 0 immediately.
  - The next frame's first word contains no stale bits.
